// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 controller-sequencer:
// opcodes, one-hot T-state encodings and the control word layout.
package sap1_pkg;

  localparam logic [3:0] OPC_LDA = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_OUT = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  localparam logic [5:0] T_IDLE = 6'b000000;
  localparam logic [5:0] T1     = 6'b000001;
  localparam logic [5:0] T2     = 6'b000010;
  localparam logic [5:0] T3     = 6'b000100;
  localparam logic [5:0] T4     = 6'b001000;
  localparam logic [5:0] T5     = 6'b010000;
  localparam logic [5:0] T6     = 6'b100000;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring: IDLE -> T1 -> ... -> T6 -> T1, stepping only when
// advance is high and freeze is low.
module ring_counter
  import sap1_pkg::*;
#(
  parameter int RING_LEN = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       freeze,
  output logic [5:0] t_state
);

  if (RING_LEN != 6) begin : g_len_check
    $error("ring_counter: RING_LEN must be 6");
  end

  logic [5:0] t_state_d;
  logic [5:0] t_state_q;

  always_comb begin
    t_state_d = t_state_q;
    if (advance && !freeze) begin
      if (t_state_q == T_IDLE || t_state_q == T6) t_state_d = T1;
      else                                        t_state_d = t_state_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_state_q <= T_IDLE;
    else        t_state_q <= t_state_d;
  end

  assign t_state = t_state_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: T-state ring plus opcode decode into the
// per-state control word, and the sticky HLT flag.
module control_sequencer
  import sap1_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int RING_LEN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic [OPC_W-1:0] opcode,
  output logic [5:0]       t_state,
  output logic             cp,
  output logic             ep,
  output logic             lm,
  output logic             ce,
  output logic             li,
  output logic             ei,
  output logic             la,
  output logic             ea,
  output logic             su,
  output logic             eu,
  output logic             lb,
  output logic             lo,
  output logic             halted
);

  logic       advance;
  logic       hlt_at_t4;
  logic       halted_d;
  logic       halted_q;
  ctrl_word_t ctrl;

  assign advance   = run | step;
  assign hlt_at_t4 = (t_state == T4) && (opcode == OPC_W'(OPC_HLT));
  // HLT latches on the edge that would otherwise have left T4, so the ring
  // never moves past T4 for a halt instruction.
  assign halted_d  = halted_q | (hlt_at_t4 & advance);

  ring_counter #(.RING_LEN(RING_LEN)) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .freeze  (halted_q | hlt_at_t4),
    .t_state (t_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  always_comb begin
    ctrl = '0;
    if (!halted_q) begin
      case (t_state)
        T1: begin ctrl.ep = 1'b1; ctrl.lm = 1'b1; end
        T2: ctrl.cp = 1'b1;
        T3: begin ctrl.ce = 1'b1; ctrl.li = 1'b1; end
        T4: begin
          if (opcode == OPC_W'(OPC_LDA) || opcode == OPC_W'(OPC_ADD) ||
              opcode == OPC_W'(OPC_SUB)) begin
            ctrl.ei = 1'b1; ctrl.lm = 1'b1;
          end else if (opcode == OPC_W'(OPC_OUT)) begin
            ctrl.ea = 1'b1; ctrl.lo = 1'b1;
          end
        end
        T5: begin
          if (opcode == OPC_W'(OPC_LDA)) begin
            ctrl.ce = 1'b1; ctrl.la = 1'b1;
          end else if (opcode == OPC_W'(OPC_ADD) || opcode == OPC_W'(OPC_SUB)) begin
            ctrl.ce = 1'b1; ctrl.lb = 1'b1;
          end
        end
        T6: begin
          if (opcode == OPC_W'(OPC_ADD) || opcode == OPC_W'(OPC_SUB)) begin
            ctrl.eu = 1'b1; ctrl.la = 1'b1;
            ctrl.su = (opcode == OPC_W'(OPC_SUB));
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign cp     = ctrl.cp;
  assign ep     = ctrl.ep;
  assign lm     = ctrl.lm;
  assign ce     = ctrl.ce;
  assign li     = ctrl.li;
  assign ei     = ctrl.ei;
  assign la     = ctrl.la;
  assign ea     = ctrl.ea;
  assign su     = ctrl.su;
  assign eu     = ctrl.eu;
  assign lb     = ctrl.lb;
  assign lo     = ctrl.lo;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-step model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [5:0] t_state;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .opcode(opcode),
    .t_state(t_state), .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li),
    .ei(ei), .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Simple datapath around the sequencer: ALU result on the bus when eu=1.
  logic [7:0] reg_a = 8'h38;
  logic [7:0] reg_b = 8'h69;
  logic [7:0] bus;
  assign bus = eu ? (su ? reg_a - reg_b : reg_a + reg_b) : 8'h00;

  // Model: instruction step number 0 (idle) .. 6, plus halt flag.
  int   m_step = 0;
  logic m_halt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt && (run || step)) begin
      if (m_step == 4 && opcode == 4'b1111) m_halt <= 1'b1;
      else m_step <= (m_step == 6) ? 1 : m_step + 1;
    end
  end

  // Bit order: cp ep lm ce li ei la ea su eu lb lo
  function automatic logic [11:0] exp_ctrl(int s, logic [3:0] op, logic h);
    logic c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo;
    {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo} = '0;
    if (!h) begin
      if (s == 1) begin c_ep = 1; c_lm = 1; end
      if (s == 2) c_cp = 1;
      if (s == 3) begin c_ce = 1; c_li = 1; end
      if (op == 4'b0000) begin
        if (s == 4) begin c_ei = 1; c_lm = 1; end
        if (s == 5) begin c_ce = 1; c_la = 1; end
      end
      if (op == 4'b0001 || op == 4'b0010) begin
        if (s == 4) begin c_ei = 1; c_lm = 1; end
        if (s == 5) begin c_ce = 1; c_lb = 1; end
        if (s == 6) begin c_eu = 1; c_la = 1; c_su = (op == 4'b0010); end
      end
      if (op == 4'b1110 && s == 4) begin c_ea = 1; c_lo = 1; end
    end
    return {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo};
  endfunction

  logic [11:0] dut_ctrl;
  assign dut_ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    logic [5:0]  exp_t;
    logic [11:0] exp_c;
    exp_t = (m_step == 0) ? 6'b000000 : 6'(1 << (m_step - 1));
    exp_c = exp_ctrl(m_step, opcode, m_halt);
    checks++;
    if (t_state !== exp_t) begin
      errors++;
      $display("FAIL model_t_state got %b want %b at %0t", t_state, exp_t, $time);
    end
    checks++;
    if (dut_ctrl !== exp_c) begin
      errors++;
      $display("FAIL model_ctrl got %b want %b at %0t", dut_ctrl, exp_c, $time);
    end
    checks++;
    if (halted !== m_halt) begin
      errors++;
      $display("FAIL model_halted got %b want %b at %0t", halted, m_halt, $time);
    end
    checks++;
    if ($countones({ep, ce, ei, ea, eu}) > 1) begin
      errors++;
      $display("FAIL bus_exclusive drivers %b at %0t", {ep, ce, ei, ea, eu}, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] want_t;
    // Reset state
    tick();
    chk("reset_t_state", 12'(t_state), 12'h000);
    chk("reset_halted", 12'(halted), 12'h000);
    chk("reset_ctrl", dut_ctrl, 12'h000);

    // 1. LDA ring walk
    rst_n = 1'b1;
    opcode = 4'b0000;
    run = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      want_t = (k < 6) ? 6'(1 << k) : 6'b000001;
      chk("lda_ring", 12'(t_state), 12'(want_t));
      if (k == 0) chk("lda_t1_ep_lm", 12'({ep, lm}), 12'h003);
      if (k == 1) chk("lda_t2_cp", 12'(cp), 12'h001);
      if (k == 2) chk("lda_t3_ce_li", 12'({ce, li}), 12'h003);
      if (k == 4) chk("lda_t5_ce_la", 12'({ce, la}), 12'h003);
    end

    // 2. SUB then ADD at T6 through the ALU
    do_reset();
    opcode = 4'b0010;
    run = 1'b1;
    repeat (6) tick();
    chk("sub_t6_eu_la_su", 12'({eu, la, su}), 12'h007);
    chk("sub_bus", 12'(bus), 12'h0CF);
    tick();
    chk("sub_t6_one_cycle", 12'({eu, su}), 12'h000);
    do_reset();
    opcode = 4'b0001;
    run = 1'b1;
    repeat (6) tick();
    chk("add_t6_su", 12'({eu, la, su}), 12'h006);
    chk("add_bus", 12'(bus), 12'h0A1);

    // 3. HLT freezes in T4
    do_reset();
    opcode = 4'b1111;
    run = 1'b1;
    repeat (4) tick();
    chk("hlt_enter_t4", 12'(t_state), 12'h008);
    tick();
    chk("hlt_set", 12'(halted), 12'h001);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hlt_frozen_t", 12'(t_state), 12'h008);
      chk("hlt_frozen_ctrl", dut_ctrl, 12'h000);
    end
    rst_n = 1'b0;
    #1;
    chk("hlt_reset_t", 12'(t_state), 12'h000);
    chk("hlt_reset_halted", 12'(halted), 12'h000);
    run = 1'b0;
    tick();
    rst_n = 1'b1;

    // 4. Hold and single step
    opcode = 4'b0000;
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_t2", 12'(t_state), 12'h002);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_one", 12'(t_state), 12'h004);
    tick();
    chk("step_release_hold", 12'(t_state), 12'h004);
    step = 1'b1;
    repeat (2) tick();
    step = 1'b0;
    chk("step_level", 12'(t_state), 12'h010);

    // 5. Asynchronous reset mid-T5 of ADD
    do_reset();
    opcode = 4'b0001;
    run = 1'b1;
    repeat (5) tick();
    chk("add_t5_ce_lb", 12'({ce, lb}), 12'h003);
    #1 rst_n = 1'b0;
    #1;
    chk("async_t_state", 12'(t_state), 12'h000);
    chk("async_ctrl", dut_ctrl, 12'h000);
    #3 rst_n = 1'b1;
    tick();
    chk("after_reset_t1", 12'(t_state), 12'h001);

    // 6. Undefined opcode behaves as NOP after fetch
    do_reset();
    opcode = 4'b0101;
    run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) chk("nop_t1", dut_ctrl, 12'h600);
      if (k >= 4) chk("nop_exec_zero", dut_ctrl, 12'h000);
    end
    // opcode changes during fetch do not disturb T1..T3
    for (int k = 1; k <= 3; k++) begin
      opcode = 4'(k * 5);
      tick();
    end
    chk("fetch_after_opc_change", 12'(t_state), 12'h004);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
